// File: rtl/mul_div_unit_if.sv
// Request/response bundle for mul_div_unit.
// The master drives the operation request and the stage enable.
// The slave (the unit) returns busy/done and the register-file write port.
interface mul_div_unit_if;
  logic        en;
  logic        start;
  logic [1:0]  op;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  dst;
  logic        busy;
  logic        done;
  logic        rw;
  logic [4:0]  da;
  logic [31:0] din;

  modport master (
    output en, start, op, sgn, a, b, dst,
    input  busy, done, rw, da, din
  );

  modport slave (
    input  en, start, op, sgn, a, b, dst,
    output busy, done, rw, da, din
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit, one iteration per enabled clock.
// MUL uses shift-add into a 64-bit product, DIV/REM use restoring
// shift-subtract. Result is written back through the rw/da/din port.
// Optional macro MULDIV_SIGNED_EN adds two's-complement operation when sgn=1.
//
// state | meaning
// IDLE  | waiting for start (sampled only with en=1)
// RUN   | 32 datapath iterations, counted down by cnt
// DONE  | result valid, done/rw high for one enabled cycle
module mul_div_unit (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [4:0]  dst_q;
  logic [31:0] bm_q;
  logic [31:0] hi_q;   // product high half / partial remainder
  logic [31:0] lo_q;   // product low half / dividend shifting into quotient
  logic [4:0]  da_q;
  logic [31:0] din_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] trial;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic [31:0] res;

`ifdef MULDIV_SIGNED_EN
  logic        a_neg;
  logic        b_neg;
  logic        neg_q;   // product/quotient needs negation
  logic        rneg_q;  // remainder follows the sign of a
  logic [63:0] prod_f;
  logic [31:0] quo_f;
  logic [31:0] rem_f;

  assign a_neg = bus.sgn & bus.a[31];
  assign b_neg = bus.sgn & bus.b[31];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;
`else
  logic unused_sgn;

  assign unused_sgn = bus.sgn;
  assign a_mag      = bus.a;
  assign b_mag      = bus.b;
`endif

  // One datapath iteration: MUL adds then shifts right, DIV shifts left then trial-subtracts.
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? bm_q : 32'd0)};
    trial   = {hi_q, lo_q[31]} - {1'b0, bm_q};
    hi_nxt  = mul_sum[32:1];
    lo_nxt  = {mul_sum[0], lo_q[31:1]};
    if (op_q[1]) begin
      if (!trial[32]) begin
        hi_nxt = trial[31:0];
        lo_nxt = {lo_q[30:0], 1'b1};
      end else begin
        hi_nxt = {hi_q[30:0], lo_q[31]};
        lo_nxt = {lo_q[30:0], 1'b0};
      end
    end
  end

  // Result selection from the values produced by the final iteration.
`ifdef MULDIV_SIGNED_EN
  always_comb begin
    prod_f = neg_q  ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    quo_f  = neg_q  ? -lo_nxt : lo_nxt;
    rem_f  = rneg_q ? -hi_nxt : hi_nxt;
    case (op_q)
      2'd0:    res = prod_f[31:0];
      2'd1:    res = prod_f[63:32];
      2'd2:    res = quo_f;
      default: res = rem_f;
    endcase
  end
`else
  always_comb begin
    case (op_q)
      2'd0:    res = lo_nxt;
      2'd1:    res = hi_nxt;
      2'd2:    res = lo_nxt;
      default: res = hi_nxt;
    endcase
  end
`endif

  // Control FSM and datapath registers; en=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      op_q   <= 2'd0;
      dst_q  <= 5'd0;
      bm_q   <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      da_q   <= 5'd0;
      din_q  <= 32'd0;
`ifdef MULDIV_SIGNED_EN
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            cnt    <= 5'd31;
            op_q   <= bus.op;
            dst_q  <= bus.dst;
            bm_q   <= b_mag;
            hi_q   <= 32'd0;
            lo_q   <= a_mag;
`ifdef MULDIV_SIGNED_EN
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            neg_q  <= (a_neg ^ b_neg) & (bus.b != 32'd0);
            rneg_q <= a_neg;
`endif
          end
        end
        RUN: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          if (cnt == 5'd0) begin
            state <= DONE;
            da_q  <= dst_q;
            din_q <= res;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.rw   = (state == DONE);
  assign bus.da   = da_q;
  assign bus.din  = din_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized bench for mul_div_unit with an arithmetic reference model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic sg,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    int          ia;
    int          ib;
    longint      la;
    longint      lb;
    p = 64'(a) * 64'(b);
    q = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    r = (b == 32'd0) ? a : a % b;
`ifdef MULDIV_SIGNED_EN
    if (sg) begin
      ia = a;
      ib = b;
      la = ia;
      lb = ib;
      p  = la * lb;
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = ia / ib;
        r = ia % ib;
      end
    end
`else
    ia = sg ? 1 : 0;
    ib = ia;
    la = 0;
    lb = la;
`endif
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return q;
      default: return r;
    endcase
  endfunction

  // Issue one operation from a negedge, check latency, pulse and result; ends on a negedge.
  task automatic do_op(input logic [1:0] op, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dst,
                       input int stall_run, input int stall_done, input string tag);
    logic [31:0] exp;
    int          edges;
    bit          stalled;
    exp = model(op, sg, a, b);
    bus.en    = 1'b1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.sgn   = sg;
    bus.a     = a;
    bus.b     = b;
    bus.dst   = dst;
    @(negedge clk);
    edges     = 1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom);
    bus.dst   = 5'($urandom);
    bus.sgn   = 1'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    stalled = 1'b0;
    while (!bus.done && edges < 200) begin
      bus.start = (edges == 10);
      if (stall_run > 0 && !stalled && edges == 12) begin
        bus.en = 1'b0;
        repeat (stall_run) begin
          @(negedge clk);
          edges++;
        end
        bus.en  = 1'b1;
        stalled = 1'b1;
      end else begin
        @(negedge clk);
        edges++;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(edges), 32'(33 + stall_run));
    chk({tag, "_rw"}, 32'(bus.rw), 32'd1);
    chk({tag, "_da"}, 32'(bus.da), 32'(dst));
    chk({tag, "_din"}, bus.din, exp);
    if (stall_done > 0) begin
      bus.en = 1'b0;
      repeat (stall_done) @(negedge clk);
      chk({tag, "_held_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_held_din"}, bus.din, exp);
      bus.en = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, {29'd0, bus.done, bus.rw, bus.busy}, 32'd0);
    chk({tag, "_din_hold"}, bus.din, exp);
  endtask

  initial begin
    int          rw_seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.sgn   = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.dst   = 5'd0;
    #2;
    chk("reset_ctrl", {29'd0, bus.done, bus.rw, bus.busy}, 32'd0);
    chk("reset_da", 32'(bus.da), 32'd0);
    chk("reset_din", bus.din, 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);

    do_op(2'd0, 1'b0, 32'd7, 32'd6, 5'd3, 0, 0, "mul_7x6");
    chk("mul_7x6_value", bus.din, 32'd42);
    do_op(2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 0, "mulh_ones");
    chk("mulh_ones_value", bus.din, 32'hFFFF_FFFE);
    do_op(2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 0, "mull_ones");
    chk("mull_ones_value", bus.din, 32'h0000_0001);
    do_op(2'd2, 1'b0, 32'd100, 32'd7, 5'd7, 0, 0, "div_100_7");
    chk("div_100_7_value", bus.din, 32'd14);
    do_op(2'd3, 1'b0, 32'd100, 32'd7, 5'd8, 0, 0, "rem_100_7");
    chk("rem_100_7_value", bus.din, 32'd2);
    do_op(2'd2, 1'b0, 32'd5, 32'd0, 5'd9, 0, 0, "div_by_zero");
    chk("div_by_zero_value", bus.din, 32'hFFFF_FFFF);
    do_op(2'd3, 1'b0, 32'd5, 32'd0, 5'd10, 0, 0, "rem_by_zero");
    chk("rem_by_zero_value", bus.din, 32'd5);
    do_op(2'd2, 1'b0, 32'd1000, 32'd33, 5'd11, 10, 10, "stall");

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      do_op(rop, 1'($urandom), ra, rb, 5'($urandom), 0, 0, "random");
    end

    do_op(2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd12, 0, 0, "sdiv_m7_2");
    do_op(2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd13, 0, 0, "srem_m7_2");
    do_op(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 0, "sdiv_ovf");
    do_op(2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0, 0, "srem_ovf");
    do_op(2'd1, 1'b1, 32'hFFFF_FFF9, 32'd3, 5'd16, 0, 0, "smulh");
    do_op(2'd2, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd17, 0, 0, "udiv_m7_2");
`ifdef MULDIV_SIGNED_EN
    chk("sdiv_m7_2_const", model(2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
`endif

    bus.en    = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.dst   = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_ctrl", {29'd0, bus.done, bus.rw, bus.busy}, 32'd0);
    chk("midrun_rst_da", 32'(bus.da), 32'd0);
    chk("midrun_rst_din", bus.din, 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    rw_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rw) rw_seen++;
    end
    chk("midrun_rst_no_write", 32'(rw_seen), 32'd0);
    do_op(2'd0, 1'b0, 32'd12, 32'd11, 5'd21, 0, 0, "post_rst");
    chk("post_rst_value", bus.din, 32'd132);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
